hex_upcounter_ndigit: RTL and testbench

- Free-running N-digit hexadecimal up-counter that produces the digit nibbles consumed by the 8-digit seven-segment multiplexer.
- An internal prescaler divides clk down to a count tick. The digits form one cascaded counter with ripple carry, plus clear, parallel load and enable controls.
- All outputs are registered. The display stage samples `digits` directly; no handshake is needed.

---
 rtl/hex_upcounter_ndigit.sv | 91 +++++++++
 tb/tb_hex_upcounter_ndigit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/hex_upcounter_ndigit.sv
// N-digit cascaded hex up-counter with prescaler, clear/load/enable and registered pulse outputs.
// Optional macro BCD_MODE_EN: each digit rolls over at 9 instead of F.
module hex_upcounter_ndigit #(
  parameter int N_DIGITS = 8,
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   load_value,
  output logic [4*N_DIGITS-1:0]   digits,
  output logic                    tick_out,
  output logic                    wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV) + 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

`ifdef BCD_MODE_EN
  localparam logic [3:0] DMAX = 4'd9;
`else
  localparam logic [3:0] DMAX = 4'hF;
`endif

  if (DIV < 1) begin : g_div_check
    $error("hex_upcounter_ndigit: CLK_HZ/TICK_HZ must be at least 1");
  end

  logic [PW-1:0]           r_presc;
  logic [4*N_DIGITS-1:0]   r_digits;
  logic                    r_tick;
  logic                    r_wrap;

  logic                    w_tick;
  logic [N_DIGITS:0]       w_carry;
  logic [4*N_DIGITS-1:0]   w_next;

  assign w_tick = en && (r_presc == LAST);

  // Ripple carry: a digit at (or, for loaded BCD values, above) its maximum wraps and passes the carry on.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    w_next     = r_digits;
    w_carry    = '0;
    w_carry[0] = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_carry[i]) begin
        if (r_digits[4*i +: 4] >= DMAX) begin
          w_next[4*i +: 4] = 4'h0;
          w_carry[i+1]     = 1'b1;
        end else begin
          w_next[4*i +: 4] = r_digits[4*i +: 4] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rstn) begin
      r_presc  <= '0;
      r_digits <= '0;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
    end else if (clear) begin
      r_presc  <= '0;
      r_digits <= '0;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
    end else if (load) begin
      r_presc  <= '0;
      r_digits <= load_value;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      if (en) r_presc <= (r_presc == LAST) ? '0 : r_presc + 1'b1;
      if (w_tick) r_digits <= w_next;
      r_tick <= w_tick;
      r_wrap <= w_tick && w_carry[N_DIGITS];
    end
  end

  assign digits   = r_digits;
  assign tick_out = r_tick;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_hex_upcounter_ndigit.sv
// Directed bench for hex_upcounter_ndigit with DIV = 10 (CLK_HZ=10, TICK_HZ=1), 8 digits.
// Expected values track BCD_MODE_EN where hex and BCD results differ.
module tb_hex_upcounter_ndigit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        clear;
  logic        load;
  logic [31:0] load_value;
  logic [31:0] digits;
  logic        tick_out;
  logic        wrap;

  int errors = 0;
  int checks = 0;
  int n;
  bit quiet_ok;

  hex_upcounter_ndigit #(.N_DIGITS(8), .CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .digits     (digits),
    .tick_out   (tick_out),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until tick_out is seen, bounded; n is the number of edges taken.
  task automatic wait_tick(input int max_cycles, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!tick_out && cycles < max_cycles);
  endtask

  task automatic do_load(input logic [31:0] v);
    load = 1'b1;
    load_value = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; clear = 1'b0; load = 1'b0; load_value = '0;
    repeat (3) step();
    check("reset_digits", digits, 32'h0);
    check("reset_tick", {31'b0, tick_out}, 32'h0);
    check("reset_wrap", {31'b0, wrap}, 32'h0);

    rstn = 1'b1;
    repeat (9) step();
    check("pre_first_tick_digits", digits, 32'h0);
    step();
    check("first_tick_out", {31'b0, tick_out}, 32'h1);
    check("first_tick_digits", digits, 32'h1);
    step();
    check("tick_one_cycle", {31'b0, tick_out}, 32'h0);
    wait_tick(30, n);
    check("second_tick_period", n, 32'd9);
    check("second_tick_digits", digits, 32'h2);

    do_load(32'h0000000F);
    check("load_F_digits", digits, 32'h0000000F);
    check("load_F_tick", {31'b0, tick_out}, 32'h0);
    wait_tick(30, n);
    check("carry_period", n, 32'd10);
    check("carry_digits", digits, 32'h00000010);
    check("carry_wrap", {31'b0, wrap}, 32'h0);

    do_load(32'hFFFFFFFF);
    wait_tick(30, n);
    check("overflow_digits", digits, 32'h0);
    check("overflow_tick", {31'b0, tick_out}, 32'h1);
    check("overflow_wrap", {31'b0, wrap}, 32'h1);
    step();
    check("overflow_wrap_width", {30'b0, wrap, tick_out}, 32'h0);

    // clear beats load and a coincident tick; prescaler restarts from 0.
    do_load(32'h00001234);
    repeat (9) step();
    clear = 1'b1; load = 1'b1; load_value = 32'h0000ABCD;
    step();
    clear = 1'b0; load = 1'b0;
    check("clear_prio_digits", digits, 32'h0);
    check("clear_prio_tick", {31'b0, tick_out}, 32'h0);
    wait_tick(30, n);
    check("clear_next_tick_period", n, 32'd10);
    check("clear_next_tick_digits", digits, 32'h1);

    // load discards a coincident tick.
    do_load(32'h00001234);
    repeat (9) step();
    do_load(32'h00005555);
    check("load_prio_digits", digits, 32'h00005555);
    check("load_prio_tick", {31'b0, tick_out}, 32'h0);
    wait_tick(30, n);
    check("load_prio_next_period", n, 32'd10);
    check("load_prio_next_digits", digits, 32'h00005556);

    // Freeze at prescaler = 4 for 50 cycles.
    repeat (4) step();
    en = 1'b0;
    quiet_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tick_out || digits !== 32'h00005556) quiet_ok = 1'b0;
    end
    check("en_low_hold", {31'b0, quiet_ok}, 32'h1);
    en = 1'b1;
    wait_tick(30, n);
    check("en_resume_period", n, 32'd6);
    check("en_resume_digits", digits, 32'h00005557);

    // Decimal-sensitive vectors.
    do_load(32'h00000099);
    wait_tick(30, n);
`ifdef BCD_MODE_EN
    check("vec_99", digits, 32'h00000100);
`else
    check("vec_99", digits, 32'h0000009A);
`endif
    do_load(32'h0000000C);
    wait_tick(30, n);
`ifdef BCD_MODE_EN
    check("vec_0C", digits, 32'h00000010);
`else
    check("vec_0C", digits, 32'h0000000D);
`endif

    // Async reset mid-operation, then restart from zero.
    do_load(32'h00ABCDEF);
    repeat (3) step();
    #2 rstn = 1'b0;
    #1;
    check("async_reset_digits", digits, 32'h0);
    step();
    rstn = 1'b1;
    wait_tick(30, n);
    check("post_reset_period", n, 32'd10);
    check("post_reset_digits", digits, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
